// File: rtl/read_arb_pkg.sv
// Shared widths, latency constants and bus payload types for the read arbiter.
//   PORT_NUM         number of requesting read ports
//   ROW_PARA         bank-enable width
//   ADDR_WIDTH       read address width
//   DATA_WIDTH       read data width
//   MEM_LATENCY      cycles from memory strobe to memory data (1..3 usable)
//   READ_PORT_MARGIN depth of free space a read port keeps when it drops nostall
package read_arb_pkg;

  localparam int unsigned PORT_NUM         = 3;
  localparam int unsigned ROW_PARA         = 4;
  localparam int unsigned ADDR_WIDTH       = 48;
  localparam int unsigned DATA_WIDTH       = 256;
  localparam int unsigned MEM_LATENCY      = 2;
  localparam int unsigned READ_PORT_MARGIN = 5;

  // Grant-to-valid latency must fit inside the port FIFO margin.
  localparam bit LATENCY_OK = (MEM_LATENCY >= 1) && (MEM_LATENCY + 2 <= READ_PORT_MARGIN);

  // Index width for an N-entry vector, never zero.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned PTR_W = idx_width(PORT_NUM);

  typedef logic [PORT_NUM-1:0] port_vec_t;

  // Payload forwarded to the bank memory for one granted request.
  typedef struct packed {
    logic [ROW_PARA-1:0]   bank_en;
    logic [ADDR_WIDTH-1:0] addr;
  } mem_req_t;

endpackage

// File: rtl/read_arbiter_if.sv
// Read-port side bus of the arbiter, all PORT_NUM ports packed side by side.
//   slave  : arbiter view (requests in, grant/return out)
//   master : read-port view (requests out, grant/return in)
interface read_arbiter_if
  import read_arb_pkg::*;
;
  logic [PORT_NUM-1:0]            read_en_i;
  logic [PORT_NUM*ROW_PARA-1:0]   read_bank_en_i;
  logic [PORT_NUM*ADDR_WIDTH-1:0] read_addr_i;
  logic [PORT_NUM-1:0]            read_nostall_i;
  logic [PORT_NUM-1:0]            read_addr_ready_o;
  logic [PORT_NUM-1:0]            read_data_valid_o;
  logic [DATA_WIDTH-1:0]          read_data_o;

  modport slave (
    input  read_en_i, read_bank_en_i, read_addr_i, read_nostall_i,
    output read_addr_ready_o, read_data_valid_o, read_data_o
  );

  modport master (
    output read_en_i, read_bank_en_i, read_addr_i, read_nostall_i,
    input  read_addr_ready_o, read_data_valid_o, read_data_o
  );

endinterface

// File: rtl/read_arbiter_rr_grant.sv
// Combinational round-robin grant: first set request at or after i_ptr, wrapping.
//   i_req     request vector
//   i_ptr     search start index (< N)
//   o_grant_c one-hot grant, zero when nothing requests
module rr_grant
  import read_arb_pkg::*;
#(
  parameter int unsigned N = PORT_NUM
) (
  input  logic [N-1:0]              i_req,
  input  logic [idx_width(N)-1:0]   i_ptr,
  output logic [N-1:0]              o_grant_c
);

  localparam int unsigned SEL_W = idx_width(N);
  localparam int unsigned SUM_W = SEL_W + 1;

  logic [SUM_W-1:0] w_pos;
  logic             w_found;

  // Walk N positions from the pointer; wrap by a single subtract since ptr < N.
  always_comb begin
    o_grant_c = '0;
    w_found   = 1'b0;
    w_pos     = '0;
    for (int unsigned off = 0; off < N; off++) begin
      w_pos = SUM_W'(i_ptr) + SUM_W'(off);
      if (w_pos >= SUM_W'(N)) w_pos = w_pos - SUM_W'(N);
      if (!w_found && i_req[SEL_W'(w_pos)]) begin
        o_grant_c[SEL_W'(w_pos)] = 1'b1;
        w_found                  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/read_arbiter.sv
// Round-robin read arbiter in front of one bank memory set. Grants one port per
// cycle, forwards the request to memory and routes the fixed-latency return beat
// back to the issuing port through a one-hot tag pipeline.
//   clk, rst_p      clock, synchronous active-high reset
//   rd              read-port bus (requests, one-hot grant, one-hot return + data)
//   mem_rd_en_o     memory read strobe
//   mem_bank_en_o   memory bank enable
//   mem_addr_o      memory address
//   mem_data_i      memory data, MEM_LATENCY cycles after the strobe
//   arb_idle_o      nothing in flight
module read_arbiter
  import read_arb_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_p,
  read_arbiter_if.slave         rd,
  output logic                  mem_rd_en_o,
  output logic [ROW_PARA-1:0]   mem_bank_en_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic [DATA_WIDTH-1:0] mem_data_i,
  output logic                  arb_idle_o
);

  if (!LATENCY_OK) begin : g_bad_latency
    $error("read_arbiter: MEM_LATENCY+2 exceeds the read port FIFO margin");
  end

  port_vec_t                 w_eligible;
  port_vec_t                 w_grant;
  logic      [PTR_W-1:0]     w_ptr_nxt;
  mem_req_t                  w_req_sel;
  logic                      w_busy;

  logic      [PTR_W-1:0]     r_ptr;
  logic                      r_mem_rd_en;
  mem_req_t                  r_req;
  port_vec_t                 r_req_tag;
  port_vec_t                 r_tag [MEM_LATENCY];
  port_vec_t                 r_ret_valid;
  logic      [DATA_WIDTH-1:0] r_ret_data;

  assign w_eligible = rd.read_en_i & rd.read_nostall_i;

  rr_grant #(.N(PORT_NUM)) u_rr_grant (
    .i_req     (w_eligible),
    .i_ptr     (r_ptr),
    .o_grant_c (w_grant)
  );

  // Slice mux of the granted port and the pointer value that follows it.
  always_comb begin
    w_ptr_nxt = r_ptr;
    w_req_sel = '0;
    for (int unsigned k = 0; k < PORT_NUM; k++) begin
      if (w_grant[k]) begin
        w_ptr_nxt         = (k == PORT_NUM - 1) ? '0 : PTR_W'(k + 1);
        w_req_sel.bank_en = w_req_sel.bank_en | rd.read_bank_en_i[k*ROW_PARA +: ROW_PARA];
        w_req_sel.addr    = w_req_sel.addr | rd.read_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  // Round-robin pointer, advances only on a grant.
  always_ff @(posedge clk) begin
    if (rst_p)          r_ptr <= '0;
    else if (|w_grant)  r_ptr <= w_ptr_nxt;
  end

  // Request stage: strobe and tag every cycle, payload only on a grant.
  always_ff @(posedge clk) begin
    if (rst_p) begin
      r_mem_rd_en <= 1'b0;
      r_req_tag   <= '0;
      r_req       <= '0;
    end else begin
      r_mem_rd_en <= |w_grant;
      r_req_tag   <= w_grant;
      if (|w_grant) r_req <= w_req_sel;
    end
  end

  // Tag pipeline: last stage lines up with mem_data_i for the same request.
  always_ff @(posedge clk) begin
    if (rst_p) begin
      for (int unsigned i = 0; i < MEM_LATENCY; i++) r_tag[i] <= '0;
    end else begin
      r_tag[0] <= r_req_tag;
      for (int unsigned i = 1; i < MEM_LATENCY; i++) r_tag[i] <= r_tag[i-1];
    end
  end

  // Return stage: data captured only alongside a live tag, held otherwise.
  always_ff @(posedge clk) begin
    if (rst_p) begin
      r_ret_valid <= '0;
      r_ret_data  <= '0;
    end else begin
      r_ret_valid <= r_tag[MEM_LATENCY-1];
      if (|r_tag[MEM_LATENCY-1]) r_ret_data <= mem_data_i;
    end
  end

  always_comb begin
    w_busy = r_mem_rd_en | (|r_req_tag) | (|r_ret_valid);
    for (int unsigned i = 0; i < MEM_LATENCY; i++) w_busy = w_busy | (|r_tag[i]);
  end

  assign rd.read_addr_ready_o = w_grant;
  assign rd.read_data_valid_o = r_ret_valid;
  assign rd.read_data_o       = r_ret_data;
  assign mem_rd_en_o          = r_mem_rd_en;
  assign mem_bank_en_o        = r_req.bank_en;
  assign mem_addr_o           = r_req.addr;
  assign arb_idle_o           = ~w_busy;

endmodule

// File: tb/tb_read_arbiter.sv
// Directed bench for read_arbiter with a fixed-latency memory model.
module tb_read_arbiter;
  import read_arb_pkg::*;

  localparam int LAT = int'(MEM_LATENCY) + 2;

  logic         clk = 1'b0;
  logic         rst_p;
  logic         mem_rd_en;
  logic [3:0]   mem_bank_en;
  logic [47:0]  mem_addr;
  logic [255:0] mem_data;
  logic         arb_idle;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  read_arbiter_if rif();

  read_arbiter dut (
    .clk           (clk),
    .rst_p         (rst_p),
    .rd            (rif),
    .mem_rd_en_o   (mem_rd_en),
    .mem_bank_en_o (mem_bank_en),
    .mem_addr_o    (mem_addr),
    .mem_data_i    (mem_data),
    .arb_idle_o    (arb_idle)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [255:0] mdata(input logic [47:0] a);
    return {16'hBEEF, a, ~a, a ^ 48'h5A5A_5A5A_5A5A, ~a, a};
  endfunction

  function automatic int oh2i(input logic [2:0] v);
    for (int k = 0; k < 3; k++) if (v[k]) return k;
    return 0;
  endfunction

  // Memory: returns mdata(addr) MEM_LATENCY cycles after a strobe, junk otherwise.
  logic [48:0] mpipe [MEM_LATENCY];
  initial for (int i = 0; i < int'(MEM_LATENCY); i++) mpipe[i] = '0;
  always @(posedge clk) begin
    mpipe[0] <= {mem_rd_en, mem_addr};
    for (int i = 1; i < int'(MEM_LATENCY); i++) mpipe[i] <= mpipe[i-1];
  end
  always_comb
    mem_data = mpipe[MEM_LATENCY-1][48] ? mdata(mpipe[MEM_LATENCY-1][47:0])
                                        : {8{32'(cyc) ^ 32'hDEAD_0000}};

  logic [47:0] addr_tab [3] = '{48'h080, 48'h100, 48'h180};
  logic [3:0]  bank_tab [3] = '{4'b0001, 4'b0011, 4'b0111};
  logic [2:0]  rr_tab   [3] = '{3'b001, 3'b010, 3'b100};

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_fixed_addrs;
    for (int k = 0; k < 3; k++) begin
      rif.read_addr_i[k*48 +: 48]  = addr_tab[k];
      rif.read_bank_en_i[k*4 +: 4] = bank_tab[k];
    end
  endtask

  task automatic do_reset;
    rst_p = 1'b1;
    rif.read_en_i = '0;
    rif.read_nostall_i = '0;
    step;
    step;
    rst_p = 1'b0;
    set_fixed_addrs;
  endtask

  task automatic test_reset;
    rst_p = 1'b1;
    rif.read_en_i = '0;
    rif.read_nostall_i = '0;
    set_fixed_addrs;
    step;
    step;
    #1;
    total++; if (rif.read_addr_ready_o !== 3'b000) begin bad++; $display("FAIL reset_ready got %b want 000", rif.read_addr_ready_o); end
    total++; if (mem_rd_en !== 1'b0) begin bad++; $display("FAIL reset_mem_rd_en got %b want 0", mem_rd_en); end
    total++; if (mem_bank_en !== 4'h0) begin bad++; $display("FAIL reset_bank got %h want 0", mem_bank_en); end
    total++; if (mem_addr !== 48'h0) begin bad++; $display("FAIL reset_addr got %h want 0", mem_addr); end
    total++; if (rif.read_data_valid_o !== 3'b000) begin bad++; $display("FAIL reset_valid got %b want 000", rif.read_data_valid_o); end
    total++; if (rif.read_data_o !== 256'h0) begin bad++; $display("FAIL reset_data got %h want 0", rif.read_data_o); end
    total++; if (arb_idle !== 1'b1) begin bad++; $display("FAIL reset_idle got %b want 1", arb_idle); end
    rst_p = 1'b0;
    step;
  endtask

  task automatic test_single;
    do_reset;
    rif.read_nostall_i = 3'b111;
    rif.read_en_i = 3'b010;
    #1;
    total++; if (rif.read_addr_ready_o !== 3'b010) begin bad++; $display("FAIL single_grant got %b want 010", rif.read_addr_ready_o); end
    step;
    rif.read_en_i = 3'b000;
    #1;
    total++; if (mem_rd_en !== 1'b1) begin bad++; $display("FAIL single_mem_rd_en got %b want 1", mem_rd_en); end
    total++; if (mem_addr !== 48'h100) begin bad++; $display("FAIL single_mem_addr got %h want 100", mem_addr); end
    total++; if (mem_bank_en !== 4'b0011) begin bad++; $display("FAIL single_mem_bank got %b want 0011", mem_bank_en); end
    total++; if (arb_idle !== 1'b0) begin bad++; $display("FAIL single_busy got %b want 0", arb_idle); end
    step;
    step;
    #1;
    total++; if (rif.read_data_valid_o !== 3'b000) begin bad++; $display("FAIL single_early_valid got %b want 000", rif.read_data_valid_o); end
    step;
    #1;
    total++; if (rif.read_data_valid_o !== 3'b010) begin bad++; $display("FAIL single_valid got %b want 010", rif.read_data_valid_o); end
    total++; if (rif.read_data_o !== mdata(48'h100)) begin bad++; $display("FAIL single_data got %h want %h", rif.read_data_o, mdata(48'h100)); end
    step;
    #1;
    total++; if (rif.read_data_valid_o !== 3'b000) begin bad++; $display("FAIL single_valid_drop got %b want 000", rif.read_data_valid_o); end
    total++; if (rif.read_data_o !== mdata(48'h100)) begin bad++; $display("FAIL single_data_hold got %h want %h", rif.read_data_o, mdata(48'h100)); end
    total++; if (arb_idle !== 1'b1) begin bad++; $display("FAIL single_idle got %b want 1", arb_idle); end
  endtask

  task automatic test_round_robin;
    logic [2:0] eg, ev;
    do_reset;
    rif.read_nostall_i = 3'b111;
    for (int i = 0; i < 12; i++) begin
      rif.read_en_i = (i < 6) ? 3'b111 : 3'b000;
      #1;
      eg = (i < 6) ? rr_tab[i % 3] : 3'b000;
      total++; if (rif.read_addr_ready_o !== eg) begin bad++; $display("FAIL rr_grant[%0d] got %b want %b", i, rif.read_addr_ready_o, eg); end
      if (i >= 1 && i <= 6) begin
        total++; if (mem_rd_en !== 1'b1 || mem_addr !== addr_tab[(i-1) % 3]) begin bad++; $display("FAIL rr_mem[%0d] got en=%b addr=%h want en=1 addr=%h", i, mem_rd_en, mem_addr, addr_tab[(i-1) % 3]); end
      end
      if (i >= LAT) begin
        ev = (i - LAT < 6) ? rr_tab[(i - LAT) % 3] : 3'b000;
        total++; if (rif.read_data_valid_o !== ev) begin bad++; $display("FAIL rr_valid[%0d] got %b want %b", i, rif.read_data_valid_o, ev); end
        if (ev != 3'b000) begin
          total++; if (rif.read_data_o !== mdata(addr_tab[(i - LAT) % 3])) begin bad++; $display("FAIL rr_data[%0d] got %h want %h", i, rif.read_data_o, mdata(addr_tab[(i - LAT) % 3])); end
        end
      end
      step;
    end
  endtask

  task automatic test_stall;
    logic [2:0] ns_tab [13] = '{3'b110, 3'b110, 3'b110, 3'b110, 3'b111, 3'b110, 3'b110,
                                3'b110, 3'b110, 3'b110, 3'b110, 3'b110, 3'b110};
    logic [2:0] g_tab  [13] = '{3'b010, 3'b100, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100,
                                3'b010, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
    logic [2:0] ev;
    do_reset;
    for (int i = 0; i < 13; i++) begin
      rif.read_en_i      = (i < 8) ? 3'b111 : 3'b000;
      rif.read_nostall_i = ns_tab[i];
      #1;
      total++; if (rif.read_addr_ready_o !== g_tab[i]) begin bad++; $display("FAIL stall_grant[%0d] got %b want %b", i, rif.read_addr_ready_o, g_tab[i]); end
      ev = (i >= LAT) ? g_tab[i - LAT] : 3'b000;
      total++; if (rif.read_data_valid_o !== ev) begin bad++; $display("FAIL stall_valid[%0d] got %b want %b", i, rif.read_data_valid_o, ev); end
      if (ev != 3'b000) begin
        total++; if (rif.read_data_o !== mdata(addr_tab[oh2i(ev)])) begin bad++; $display("FAIL stall_data[%0d] got %h want %h", i, rif.read_data_o, mdata(addr_tab[oh2i(ev)])); end
      end
      step;
    end
  endtask

  task automatic test_no_request;
    do_reset;
    rif.read_nostall_i = 3'b111;
    rif.read_en_i = 3'b001;
    #1;
    total++; if (rif.read_addr_ready_o !== 3'b001) begin bad++; $display("FAIL idle_first_grant got %b want 001", rif.read_addr_ready_o); end
    step;
    rif.read_en_i = 3'b000;
    for (int i = 0; i < 6; i++) step;
    for (int i = 0; i < 10; i++) begin
      #1;
      total++; if (rif.read_addr_ready_o !== 3'b000 || mem_rd_en !== 1'b0 || rif.read_data_valid_o !== 3'b000 || arb_idle !== 1'b1)
        begin bad++; $display("FAIL idle_quiet[%0d] got ready=%b rd=%b valid=%b idle=%b want 000/0/000/1", i, rif.read_addr_ready_o, mem_rd_en, rif.read_data_valid_o, arb_idle); end
      step;
    end
    rif.read_en_i = 3'b111;
    rif.read_nostall_i = 3'b000;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (rif.read_addr_ready_o !== 3'b000) begin bad++; $display("FAIL idle_all_stalled[%0d] got %b want 000", i, rif.read_addr_ready_o); end
      step;
    end
    rif.read_nostall_i = 3'b111;
    #1;
    total++; if (rif.read_addr_ready_o !== 3'b010) begin bad++; $display("FAIL idle_ptr_held got %b want 010", rif.read_addr_ready_o); end
    step;
    rif.read_en_i = 3'b000;
    for (int i = 0; i < 6; i++) step;
  endtask

  task automatic test_reset_mid;
    do_reset;
    rif.read_nostall_i = 3'b111;
    for (int i = 0; i < 3; i++) begin
      rif.read_en_i = 3'b111;
      #1;
      total++; if (rif.read_addr_ready_o !== rr_tab[i]) begin bad++; $display("FAIL rmid_grant[%0d] got %b want %b", i, rif.read_addr_ready_o, rr_tab[i]); end
      step;
    end
    rif.read_en_i = 3'b000;
    rst_p = 1'b1;
    step;
    rst_p = 1'b0;
    #1;
    total++; if (mem_rd_en !== 1'b0 || mem_bank_en !== 4'h0 || mem_addr !== 48'h0) begin bad++; $display("FAIL rmid_req_clear got rd=%b bank=%h addr=%h want 0/0/0", mem_rd_en, mem_bank_en, mem_addr); end
    total++; if (rif.read_data_valid_o !== 3'b000 || rif.read_data_o !== 256'h0) begin bad++; $display("FAIL rmid_ret_clear got valid=%b data=%h want 000/0", rif.read_data_valid_o, rif.read_data_o); end
    total++; if (arb_idle !== 1'b1) begin bad++; $display("FAIL rmid_idle got %b want 1", arb_idle); end
    for (int i = 0; i < 8; i++) begin
      step;
      #1;
      total++; if (rif.read_data_valid_o !== 3'b000 || arb_idle !== 1'b1) begin bad++; $display("FAIL rmid_no_valid[%0d] got valid=%b idle=%b want 000/1", i, rif.read_data_valid_o, arb_idle); end
    end
  endtask

  typedef struct {
    int           due;
    logic [2:0]   port;
    logic [255:0] data;
  } exp_t;

  task automatic test_random;
    exp_t        q[$];
    exp_t        e;
    logic [47:0] a [3];
    logic [2:0]  elig, eg;
    int          ptr_m, gk;
    do_reset;
    ptr_m = 0;
    for (int i = 0; i < 1506; i++) begin
      for (int k = 0; k < 3; k++) begin
        a[k] = {16'($urandom), 32'($urandom)};
        rif.read_addr_i[k*48 +: 48]  = a[k];
        rif.read_bank_en_i[k*4 +: 4] = 4'($urandom);
      end
      rif.read_en_i      = (i < 1500) ? 3'($urandom) : 3'b000;
      rif.read_nostall_i = 3'($urandom) | 3'($urandom);
      #1;
      elig = rif.read_en_i & rif.read_nostall_i;
      eg = 3'b000;
      gk = 0;
      for (int off = 0; off < 3; off++) begin
        if (eg == 3'b000 && elig[(ptr_m + off) % 3]) begin
          gk = (ptr_m + off) % 3;
          eg[gk] = 1'b1;
        end
      end
      total++; if (rif.read_addr_ready_o !== eg) begin bad++; $display("FAIL rand_grant[%0d] got %b want %b", i, rif.read_addr_ready_o, eg); end
      if (eg != 3'b000) begin
        ptr_m  = (gk + 1) % 3;
        e.due  = i + LAT;
        e.port = eg;
        e.data = mdata(a[gk]);
        q.push_back(e);
      end
      if (q.size() > 0 && q[0].due == i) begin
        total++; if (rif.read_data_valid_o !== q[0].port || rif.read_data_o !== q[0].data)
          begin bad++; $display("FAIL rand_return[%0d] got valid=%b data=%h want valid=%b data=%h", i, rif.read_data_valid_o, rif.read_data_o, q[0].port, q[0].data); end
        void'(q.pop_front());
      end else begin
        total++; if (rif.read_data_valid_o !== 3'b000) begin bad++; $display("FAIL rand_spurious[%0d] got %b want 000", i, rif.read_data_valid_o); end
      end
      step;
    end
    total++; if (q.size() != 0) begin bad++; $display("FAIL rand_drain got %0d pending want 0", q.size()); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst_p = 1'b1;
    rif.read_en_i = '0;
    rif.read_nostall_i = '0;
    rif.read_addr_i = '0;
    rif.read_bank_en_i = '0;
    test_reset;
    test_single;
    test_round_robin;
    test_stall;
    test_no_request;
    test_reset_mid;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
